cordic_pipe: RTL and testbench
==============================

CORDIC_PIPE -- requirements
Module: cordic_pipe

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning signed x/y data width in bits (range 8..24).
REQ-002 The block SHALL have parameter ZW, default 32, meaning angle width in bits, where full scale 2^ZW = 360 deg (range 16..32).
REQ-003 The block SHALL have parameter STAGES, default 16, meaning the number of micro-rotation stages (range 8..ZW-8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input sample qualifier.
REQ-007 The block SHALL have port in_mode, input, 1 bit: operating mode, 0 = rotation, 1 = vectoring.
REQ-008 The block SHALL have ports xin and yin, input, DW bits each, signed two's complement.
REQ-009 The block SHALL have port zin, input, ZW bits: angle, two's complement (0x2000_0000 = 45 deg at ZW=32).
REQ-010 The block SHALL have port out_valid, input-aligned qualifier, output, 1 bit.
REQ-011 The block SHALL have ports xout and yout, output, DW bits each, signed.
REQ-012 The block SHALL have port zout, output, ZW bits: residual angle (rotation mode) or accumulated angle (vectoring mode).
REQ-013 The block SHALL have port out_mode, output, 1 bit: in_mode carried alongside the sample.

Function
REQ-014 The block SHALL be fully pipelined: one sample accepted per cycle when in_valid=1; no backpressure.
REQ-015 Latency SHALL be exactly STAGES+1 cycles: 1 pre-rotation register stage plus STAGES iteration register stages; out_valid = in_valid delayed by STAGES+1.
REQ-016 Internal x/y SHALL be DW+2 bits wide, sign-extended on entry; shifts SHALL be arithmetic.
REQ-017 Pre-rotation in rotation mode SHALL use zin[ZW-1:ZW-2]: 00/11 pass through; 01 gives x=-y, y=x, z with top bits set to 00; 10 gives x=y, y=-x, z with top bits set to 11.
REQ-018 Pre-rotation in vectoring mode SHALL apply when x<0: if y>=0 then x=y, y=-x, z=zin+90 deg; otherwise x=-y, y=x, z=zin-90 deg. When x>=0 the values SHALL pass through.
REQ-019 In stage i, the direction SHALL be d=+1 when (rotation: z>=0) or (vectoring: y<0); otherwise d=-1.
REQ-020 Stage i SHALL compute x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i.
REQ-021 atan_i SHALL be a ZW-bit constant equal to round(atan(2^-i)/(2*pi)*2^ZW), for i = 0..STAGES-1, generated from parameters.
REQ-022 Mode and valid SHALL travel with each sample, so mixed modes on consecutive cycles do not interfere.
REQ-023 xout and yout SHALL saturate the final DW+2-bit values to [-2^(DW-1), 2^(DW-1)-1]; zout SHALL wrap modulo 2^ZW.
REQ-024 Data registers SHALL update every cycle regardless of valid; outputs are qualified only by out_valid.

Reset
REQ-025 On rst=1, all valid and mode pipeline bits and all x/y/z registers SHALL clear to 0 immediately; out_valid, xout, yout, zout and out_mode SHALL read 0.
REQ-026 A reset mid-stream SHALL discard all in-flight samples; the first out_valid=1 after release SHALL correspond to the first in_valid=1 sampled after release, STAGES+1 cycles later.

Configuration
REQ-027 With macro CORDIC_GAIN_COMP_EN defined, the pre-rotation stage SHALL scale x and y by (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9) (approx. 0.6074), so outputs carry unity gain. Latency SHALL be unchanged.
REQ-028 Without CORDIC_GAIN_COMP_EN, no scaling SHALL be applied; outputs carry a CORDIC gain of approx. 1.6468.

Verification (DW=16, ZW=32, STAGES=16)
REQ-029 With gain compensation on, rotation mode, x=10000, y=0, z=0x4000_0000 (90 deg) -> after 17 cycles xout within 0+/-8, yout within 10000+/-12, out_valid=1 for exactly 1 cycle.
REQ-030 With gain compensation on, vectoring mode, x=y=10000, z=0 -> xout within 14142+/-16, yout within 0+/-4, zout within 0x2000_0000+/-2^17.
REQ-031 With gain compensation on, vectoring mode, x=-10000, y=-1 (quadrant III) -> zout approx. 0x8000_0000 (wrapped), xout within 10000+/-12.
REQ-032 With gain compensation off, vectoring mode, x=y=32767 -> xout=32767 (saturated), no wrap to negative values.
REQ-033 A 40-cycle random in_valid/in_mode stream -> out_valid and out_mode equal the inputs delayed by 17 cycles, and each output matches a reference model within +/-16 LSB.
REQ-034 Assert rst for 1 cycle while 10 samples are in flight -> out_valid=0 immediately and stays 0 until 17 cycles after the next accepted sample.

Source files
------------

// File: rtl/cordic_pipe.sv
//------------------------------------------------------------------------------
// cordic_pipe : fully pipelined rotation/vectoring CORDIC with saturating x/y.
// Optional gain compensation in the pre-rotation stage: CORDIC_GAIN_COMP_EN.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cordic_pipe #(
  parameter int DW     = 16,
  parameter int ZW     = 32,
  parameter int STAGES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_mode,
  input  logic signed [DW-1:0] xin,
  input  logic signed [DW-1:0] yin,
  input  logic [ZW-1:0]        zin,
  output logic                 out_valid,
  output logic signed [DW-1:0] xout,
  output logic signed [DW-1:0] yout,
  output logic [ZW-1:0]        zout,
  output logic                 out_mode
);

  localparam int XW = DW + 2;
  localparam logic [ZW-1:0] c_quarter = {2'b01, {(ZW-2){1'b0}}};

  // Elaboration-time arctangent: series for t <= 0.5, exact pi/4 for i = 0.
  function automatic logic [ZW-1:0] atan_const(input int i);
    real t, term, sum, scale;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    if (i == 0) begin
      sum = 0.78539816339744831;
    end else begin
      sum  = 0.0;
      term = t;
      for (int k = 0; k < 40; k++) begin
        sum  = (k % 2 == 0) ? sum + term / (2.0 * k + 1.0) : sum - term / (2.0 * k + 1.0);
        term = term * t * t;
      end
    end
    scale = 1.0;
    for (int k = 0; k < ZW; k++) scale = scale * 2.0;
    return ZW'($rtoi(sum / 6.28318530717958648 * scale + 0.5));
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:DW-1] == {(XW-DW+1){v[XW-1]}}) return v[DW-1:0];
    else if (v[XW-1])                          return {1'b1, {(DW-1){1'b0}}};
    else                                       return {1'b0, {(DW-1){1'b1}}};
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction
`endif

  logic [ZW-1:0] w_atan [0:STAGES-1];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_atan
    localparam logic [ZW-1:0] c_atan = atan_const(gi);
    assign w_atan[gi] = c_atan;
  end

  logic signed [XW-1:0] w_xe, w_ye, w_px, w_py, w_sx, w_sy;
  logic [ZW-1:0]        w_pz;

  // Pre-rotation folds the operand into the +/-90 deg convergence range.
  always_comb begin
    w_xe = {{2{xin[DW-1]}}, xin};
    w_ye = {{2{yin[DW-1]}}, yin};
    w_px = w_xe;
    w_py = w_ye;
    w_pz = zin;
    if (!in_mode) begin
      case (zin[ZW-1:ZW-2])
        2'b01: begin
          w_px = -w_ye;
          w_py = w_xe;
          w_pz = {2'b00, zin[ZW-3:0]};
        end
        2'b10: begin
          w_px = w_ye;
          w_py = -w_xe;
          w_pz = {2'b11, zin[ZW-3:0]};
        end
        default: ;
      endcase
    end else if (w_xe[XW-1]) begin
      if (!w_ye[XW-1]) begin
        w_px = w_ye;
        w_py = -w_xe;
        w_pz = zin + c_quarter;
      end else begin
        w_px = -w_ye;
        w_py = w_xe;
        w_pz = zin - c_quarter;
      end
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  assign w_sx = gain_comp(w_px);
  assign w_sy = gain_comp(w_py);
`else
  assign w_sx = w_px;
  assign w_sy = w_py;
`endif

  logic signed [XW-1:0] r_x [0:STAGES];
  logic signed [XW-1:0] r_y [0:STAGES];
  logic [ZW-1:0]        r_z [0:STAGES];
  logic [STAGES:0]      r_v;
  logic [STAGES:0]      r_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      r_m <= '0;
      for (int i = 0; i <= STAGES; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_z[i] <= '0;
      end
    end else begin
      r_v    <= {r_v[STAGES-1:0], in_valid};
      r_m    <= {r_m[STAGES-1:0], in_mode};
      r_x[0] <= w_sx;
      r_y[0] <= w_sy;
      r_z[0] <= w_pz;
      // d = +1 when rotation z >= 0 or vectoring y < 0.
      for (int i = 0; i < STAGES; i++) begin
        if (r_m[i] ? r_y[i][XW-1] : !r_z[i][ZW-1]) begin
          r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
          r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
          r_z[i+1] <= r_z[i] - w_atan[i];
        end else begin
          r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
          r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
          r_z[i+1] <= r_z[i] + w_atan[i];
        end
      end
    end
  end

  assign out_valid = r_v[STAGES];
  assign out_mode  = r_m[STAGES];
  assign xout      = sat(r_x[STAGES]);
  assign yout      = sat(r_y[STAGES]);
  assign zout      = r_z[STAGES];

endmodule

`default_nettype wire

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe: directed vector table, reset corner case, mixed-mode stream.
`default_nettype none

module tb_cordic_pipe;
  localparam int DW = 16, ZW = 32, STAGES = 16, LAT = STAGES + 1;
  localparam real K = 1.6467602581210656;
`ifdef CORDIC_GAIN_COMP_EN
  localparam real G = 0.607421875 * K;
`else
  localparam real G = K;
`endif
  localparam real TWO_PI = 6.28318530717958648;
  localparam real FS = 4294967296.0;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_mode = 1'b0;
  logic signed [DW-1:0] xin = '0, yin = '0;
  logic [ZW-1:0] zin = '0;
  logic out_valid, out_mode;
  logic signed [DW-1:0] xout, yout;
  logic [ZW-1:0] zout;

  int n_checks = 0, n_err = 0;

  cordic_pipe #(.DW(DW), .ZW(ZW), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode),
    .xin(xin), .yin(yin), .zin(zin), .out_valid(out_valid),
    .xout(xout), .yout(yout), .zout(zout), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mode;
    int          x, y;
    logic [31:0] z;
    int          ix, iy;   // ideal unit-gain outputs
    real         zdeg;     // ideal zout in degrees
    int          ztol;
  } vec_t;

  function automatic vec_t mk(logic m, int x, int y, logic [31:0] z, int ix, int iy, real zd, int zt);
    vec_t v;
    v.mode = m; v.x = x; v.y = y; v.z = z; v.ix = ix; v.iy = iy; v.zdeg = zd; v.ztol = zt;
    return v;
  endfunction

  function automatic int exp_xy(real ideal);
    real r;
    int  v;
    r = G * ideal;
    v = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic logic [31:0] rad2z(real a);
    real u;
    u = a / TWO_PI * FS;
    if (u >= 2147483647.0) u = u - FS;
    if (u < -2147483648.0) u = u + FS;
    return 32'($rtoi(u));
  endfunction

  task automatic chk_int(string name, int act, int exp, int tol);
    n_checks++;
    if (act - exp > tol || exp - act > tol) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic chk_z(string name, logic [31:0] act, logic [31:0] exp, int tol);
    longint d;
    d = longint'($signed(act - exp));
    n_checks++;
    if (d > tol || -d > tol) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic m, int x, int y, logic [31:0] z);
    in_valid = v; in_mode = m; xin = 16'(x); yin = 16'(y); zin = z;
  endtask

  task automatic run_vec(vec_t v, string tag);
    int early;
    early = 0;
    drive(1'b1, v.mode, v.x, v.y, v.z);
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == 1) drive(1'b0, 1'b0, 0, 0, '0);
      if (k < LAT && out_valid) early++;
    end
    chk_int({tag, "_early"}, early, 0, 0);
    chk_int({tag, "_valid"}, int'(out_valid), 1, 0);
    chk_int({tag, "_mode"},  int'(out_mode), int'(v.mode), 0);
    chk_int({tag, "_x"},     int'(xout), exp_xy(real'(v.ix)), 16);
    chk_int({tag, "_y"},     int'(yout), exp_xy(real'(v.iy)), 16);
    chk_z  ({tag, "_z"},     zout, rad2z(v.zdeg / 360.0 * TWO_PI), v.ztol);
    step();
    chk_int({tag, "_pulse"}, int'(out_valid), 0, 0);
  endtask

  vec_t tv[13];

  logic        hv [0:39], hm [0:39];
  int          hx [0:39], hy [0:39];
  logic [31:0] hz [0:39];

  initial begin
    int cnt;
    tv[0]  = mk(1'b0, 10000, 0,      32'h4000_0000, 0,     10000,  0.0,       1 << 18);
    tv[1]  = mk(1'b0, 10000, 0,      32'h0000_0000, 10000, 0,      0.0,       1 << 18);
    tv[2]  = mk(1'b0, 10000, 0,      32'hC000_0000, 0,     -10000, 0.0,       1 << 18);
    tv[3]  = mk(1'b0, 0,     8000,   32'h8000_0000, 0,     -8000,  0.0,       1 << 18);
    tv[4]  = mk(1'b0, 10000, 0,      32'h2000_0000, 7071,  7071,   0.0,       1 << 18);
    tv[5]  = mk(1'b1, 10000, 10000,  32'h0000_0000, 14142, 0,      45.0,      1 << 17);
    tv[6]  = mk(1'b1, -10000, -1,    32'h0000_0000, 10000, 0,      -180.0,    1 << 18);
    tv[7]  = mk(1'b1, 32767, 32767,  32'h0000_0000, 46339, 0,      45.0,      1 << 18);
    tv[8]  = mk(1'b1, -8000, 6000,   32'h1000_0000, 10000, 0,      165.63010, 1 << 18);
    tv[9]  = mk(1'b1, 0,     -5000,  32'h0000_0000, 5000,  0,      -90.0,     1 << 18);
    tv[10] = mk(1'b0, -12000, 5000,  32'h6000_0000, 4950,  -12021, 0.0,       1 << 18);
    tv[11] = mk(1'b0, 32767, 32767,  32'h0000_0000, 32767, 32767,  0.0,       1 << 18);
    tv[12] = mk(1'b0, -32768, -32768, 32'h0000_0000, -32768, -32768, 0.0,     1 << 18);

    // Reset state
    repeat (3) step();
    chk_int("rst_valid", int'(out_valid), 0, 0);
    chk_int("rst_mode",  int'(out_mode), 0, 0);
    chk_int("rst_x",     int'(xout), 0, 0);
    chk_int("rst_y",     int'(yout), 0, 0);
    chk_z  ("rst_z",     zout, 32'h0, 0);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 13; i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Mid-stream reset with samples in flight
    for (int k = 0; k < 25; k++) begin
      drive(1'b1, 1'b1, 1000, 1000, 32'h0);
      step();
    end
    chk_int("prerst_valid", int'(out_valid), 1, 0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, '0);
    #1;
    chk_int("midrst_valid", int'(out_valid), 0, 0);
    chk_int("midrst_mode",  int'(out_mode), 0, 0);
    chk_int("midrst_x",     int'(xout), 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (out_valid) cnt++;
    end
    chk_int("postrst_quiet", cnt, 0, 0);
    run_vec(tv[1], "postrst");

    // Mixed-mode random stream
    for (int s = 0; s < 40; s++) begin
      hv[s] = 1'($urandom_range(0, 1));
      hm[s] = 1'($urandom_range(0, 1));
      hx[s] = int'($urandom_range(4000, 12000));
      if ($urandom_range(0, 1) == 1) hx[s] = -hx[s];
      hy[s] = int'($urandom_range(0, 24000)) - 12000;
      hz[s] = $urandom;
    end
    for (int s = 0; s < 40 + LAT; s++) begin
      if (s >= LAT) begin
        int  j;
        real th, ex, ey;
        logic [31:0] ez;
        j = s - LAT;
        chk_int($sformatf("rnd%0d_valid", j), int'(out_valid), int'(hv[j]), 0);
        if (hv[j]) begin
          if (hm[j]) begin
            ex = $sqrt(real'(hx[j]) * hx[j] + real'(hy[j]) * hy[j]);
            ey = 0.0;
            ez = hz[j] + rad2z($atan2(real'(hy[j]), real'(hx[j])));
          end else begin
            th = real'($signed(hz[j])) / FS * TWO_PI;
            ex = hx[j] * $cos(th) - hy[j] * $sin(th);
            ey = hx[j] * $sin(th) + hy[j] * $cos(th);
            ez = 32'h0;
          end
          chk_int($sformatf("rnd%0d_mode", j), int'(out_mode), int'(hm[j]), 0);
          chk_int($sformatf("rnd%0d_x", j), int'(xout), exp_xy(ex), 16);
          chk_int($sformatf("rnd%0d_y", j), int'(yout), exp_xy(ey), 16);
          chk_z  ($sformatf("rnd%0d_z", j), zout, ez, 1 << 20);
        end
      end else begin
        chk_int($sformatf("rnd_pre%0d_valid", s), int'(out_valid), 0, 0);
      end
      if (s < 40) drive(hv[s], hm[s], hx[s], hy[s], hz[s]);
      else        drive(1'b0, 1'b0, 0, 0, '0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
